// File: rtl/uart_fifo_tx.sv
// 8N1/8N2 UART transmitter that pops bytes from a FIFO read port and drives the tx pin; tx falls 2 cycles after IDLE accepts a byte.
// Defining UART_FIFO_TX_PARITY_EN adds one even-parity bit after the data bits; undefined gives plain 8N1/8N2 frames.
module uart_fifo_tx #(
  parameter int CLK_HZ    = 50000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk1_50,
  input  logic                 rst_,
  input  logic                 en,
  input  logic                 fifo_empty,
  output logic                 fifo_re,
  input  logic [DATA_BITS-1:0] fifo_dout,
  output logic                 tx,
  output logic                 busy
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LAST_DATA   = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] LAST_STOP   = CW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    START,
    DATA,
`ifdef UART_FIFO_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state_q;
  logic                 tx_q;
  logic                 fifo_re_q;
  logic [CW-1:0]        bit_q;
  logic [BW-1:0]        baud_q;
  logic [DATA_BITS-1:0] shreg_q;
`ifdef UART_FIFO_TX_PARITY_EN
  logic                 par_q;
`endif

  logic start_ok;
  logic baud_zero;

  assign start_ok  = en && !fifo_empty;
  assign baud_zero = (baud_q == '0);

  always_ff @(posedge clk1_50 or negedge rst_) begin
    if (!rst_) begin
      state_q   <= IDLE;
      tx_q      <= 1'b1;
      fifo_re_q <= 1'b0;
      bit_q     <= '0;
      baud_q    <= '0;
      shreg_q   <= '0;
`ifdef UART_FIFO_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      fifo_re_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_q   <= FETCH;
            fifo_re_q <= 1'b1;
          end
        end
        FETCH: state_q <= LATCH;
        LATCH: begin
          shreg_q <= fifo_dout;
          baud_q  <= BAUD_RELOAD;
          tx_q    <= 1'b0;
          state_q <= START;
`ifdef UART_FIFO_TX_PARITY_EN
          par_q   <= ^fifo_dout;
`endif
        end
        START: begin
          if (baud_zero) begin
            baud_q  <= BAUD_RELOAD;
            bit_q   <= '0;
            tx_q    <= shreg_q[0];
            shreg_q <= shreg_q >> 1;
            state_q <= DATA;
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        DATA: begin
          if (baud_zero) begin
            baud_q <= BAUD_RELOAD;
            if (bit_q == LAST_DATA) begin
              bit_q   <= '0;
`ifdef UART_FIFO_TX_PARITY_EN
              tx_q    <= par_q;
              state_q <= PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= STOP;
`endif
            end else begin
              bit_q   <= bit_q + 1'b1;
              tx_q    <= shreg_q[0];
              shreg_q <= shreg_q >> 1;
            end
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
`ifdef UART_FIFO_TX_PARITY_EN
        PARITY: begin
          if (baud_zero) begin
            baud_q  <= BAUD_RELOAD;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            state_q <= STOP;
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_zero) begin
            if (bit_q == LAST_STOP) begin
              bit_q <= '0;
              // The last stop edge doubles as the IDLE decision so back-to-back frames gap by FETCH+LATCH only.
              if (start_ok) begin
                state_q   <= FETCH;
                fifo_re_q <= 1'b1;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              bit_q  <= bit_q + 1'b1;
              baud_q <= BAUD_RELOAD;
            end
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_re = fifo_re_q;
  assign tx      = tx_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Bench for uart_fifo_tx at 10 clocks per bit: a FIFO model feeds the DUT and each cycle's {tx,fifo_re,busy}
// is compared against a waveform computed directly from the byte list and the frame format.
`timescale 1ns/1ps
module tb_uart_fifo_tx;

  localparam int CLK_HZ    = 1000;
  localparam int BAUD      = 100;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int CPB       = CLK_HZ / BAUD;
`ifdef UART_FIFO_TX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int FRAME = (1 + DATA_BITS + PBITS + STOP_BITS) * CPB;
  localparam int SLOT  = FRAME + 2;

  logic       clk1_50 = 1'b0;
  logic       rst_;
  logic       en;
  logic       fifo_empty;
  logic       fifo_re;
  logic [7:0] fifo_dout;
  logic       tx;
  logic       busy;

  always #5 clk1_50 = ~clk1_50;

  uart_fifo_tx #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .DATA_BITS (DATA_BITS),
    .STOP_BITS (STOP_BITS)
  ) dut (
    .clk1_50    (clk1_50),
    .rst_       (rst_),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_re    (fifo_re),
    .fifo_dout  (fifo_dout),
    .tx         (tx),
    .busy       (busy)
  );

  int         tests = 0;
  int         fails = 0;
  int         underflows = 0;
  int         rd_stage = 0;
  logic [7:0] last_pop = 8'h00;
  logic [7:0] fq[$];
  logic [7:0] sent[$];
  logic [7:0] rx[$];
  logic [2:0] tr[$];
  logic [2:0] exp_tr[$];

  // One cycle: FIFO model reacts to fifo_re seen last negedge, then {tx,fifo_re,busy} is recorded.
  task automatic tick();
    @(negedge clk1_50);
    if (rd_stage == 2) begin
      fifo_dout = ~last_pop;
      rd_stage  = 0;
    end
    if (rd_stage == 1) begin
      if (fq.size() == 0) begin
        underflows++;
        last_pop = 8'h00;
      end else begin
        last_pop = fq.pop_front();
      end
      fifo_dout  = last_pop;
      fifo_empty = (fq.size() == 0);
      rd_stage   = 2;
    end
    if (fifo_re === 1'b1) begin
      rd_stage = 1;
      if (fq.size() != 0) fifo_dout = ~fq[0];
    end
    tr.push_back({tx, fifo_re, busy});
  endtask

  task automatic load(input logic [7:0] b);
    fq.push_back(b);
    sent.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic clear();
    tr.delete();
    sent.delete();
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int pos);
    if (pos == 0) return 1'b0;
    if (pos <= DATA_BITS) return b[pos-1];
    if (PBITS == 1 && pos == DATA_BITS + 1) return ^b;
    return 1'b1;
  endfunction

  // Bytes in 'sent' go out back-to-back from trace index 0: FETCH, LATCH, then the frame, repeated.
  function automatic void build_exp(input int len);
    int i;
    int off;
    exp_tr.delete();
    for (int t = 0; t < len; t++) begin
      i   = t / SLOT;
      off = t % SLOT;
      if (i < sent.size())
        exp_tr.push_back({(off < 2) ? 1'b1 : frame_bit(sent[i], (off - 2) / CPB), off == 0, 1'b1});
      else
        exp_tr.push_back(3'b100);
    end
  endfunction

  function automatic int first_diff();
    if (tr.size() != exp_tr.size()) return 0;
    foreach (tr[i]) if (tr[i] !== exp_tr[i]) return i;
    return -1;
  endfunction

  // Independent line receiver: find falling edges, sample data bits mid-bit.
  function automatic void decode();
    logic [7:0] b;
    rx.delete();
    for (int i = 1; i < tr.size(); i++) begin
      if (tr[i-1][2] == 1'b1 && tr[i][2] == 1'b0 && i + FRAME <= tr.size()) begin
        for (int j = 0; j < 8; j++) b[j] = tr[i + CPB/2 + (j + 1) * CPB][2];
        rx.push_back(b);
        i = i + (1 + DATA_BITS + PBITS) * CPB;
      end
    end
  endfunction

  task automatic test_reset();
    rst_ = 1'b0; en = 1'b0; fifo_empty = 1'b1; fifo_dout = 8'h00;
    tick(); tick();
    tests++; if (tx !== 1'b1)      begin fails++; $display("FAIL reset_tx: got %b want 1", tx); end
    tests++; if (fifo_re !== 1'b0) begin fails++; $display("FAIL reset_re: got %b want 0", fifo_re); end
    tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_ = 1'b1;
    tick();
  endtask

  task automatic test_empty_idle();
    int d;
    clear();
    en = 1'b1;
    repeat (200) tick();
    build_exp(200);
    d = first_diff();
    tests++;
    if (d != -1) begin fails++; $display("FAIL empty_idle: cycle %0d got {tx,re,busy}=%b want %b", d, tr[d], exp_tr[d]); end
  endtask

  task automatic test_single();
    int d;
    int ir;
    int it;
    int nb;
    clear();
    load(8'h55);
    repeat (SLOT + 30) tick();
    build_exp(SLOT + 30);
    d = first_diff();
    tests++;
    if (d != -1) begin fails++; $display("FAIL single_trace: cycle %0d got {tx,re,busy}=%b want %b", d, tr[d], exp_tr[d]); end
    ir = -1; it = -1; nb = 0;
    foreach (tr[i]) begin
      if (tr[i][1] && ir < 0) ir = i;
      if (!tr[i][2] && it < 0) it = i;
      if (tr[i][0]) nb++;
    end
    tests++;
    if (it - ir !== 2) begin fails++; $display("FAIL single_latency: got %0d want 2", it - ir); end
    tests++;
    if (nb !== FRAME + 2) begin fails++; $display("FAIL single_busy_len: got %0d want %0d", nb, FRAME + 2); end
    decode();
    tests++;
    if (rx.size() != 1 || rx[0] !== 8'h55) begin fails++; $display("FAIL single_decode: got %0d bytes first %h want 55", rx.size(), (rx.size() != 0) ? rx[0] : 8'h00); end
  endtask

  task automatic test_back_to_back();
    int d;
    int f2;
    int run;
    clear();
    load(8'h01);
    load(8'h02);
    repeat (2 * SLOT + 20) tick();
    build_exp(2 * SLOT + 20);
    d = first_diff();
    tests++;
    if (d != -1) begin fails++; $display("FAIL b2b_trace: cycle %0d got {tx,re,busy}=%b want %b", d, tr[d], exp_tr[d]); end
    decode();
    tests++;
    if (rx.size() < 1 || rx[0] !== 8'h01) begin fails++; $display("FAIL b2b_byte0: got %h want 01", (rx.size() > 0) ? rx[0] : 8'h00); end
    tests++;
    if (rx.size() < 2 || rx[1] !== 8'h02) begin fails++; $display("FAIL b2b_byte1: got %h want 02", (rx.size() > 1) ? rx[1] : 8'h00); end
    f2 = -1;
    for (int i = 3; i < tr.size(); i++)
      if (f2 < 0 && i > SLOT && tr[i-1][2] && !tr[i][2]) f2 = i;
    run = 0;
    for (int i = f2 - 1; i > 0 && tr[i][2]; i--) run++;
    // 0x01 ends in data bit 0; its parity bit (when present) is 1 and lengthens the high run.
    tests++;
    if (run !== STOP_BITS * CPB + 2 + PBITS * CPB) begin
      fails++; $display("FAIL b2b_gap: got %0d want %0d", run, STOP_BITS * CPB + 2 + PBITS * CPB);
    end
  endtask

  task automatic test_en_drop();
    int d;
    clear();
    load(8'hA3);
    load(8'h5A);
    for (int c = 0; c < SLOT + 40; c++) begin
      tick();
      if (c == 32) en = 1'b0;
    end
    void'(sent.pop_back());
    build_exp(SLOT + 40);
    d = first_diff();
    tests++;
    if (d != -1) begin fails++; $display("FAIL en_drop_trace: cycle %0d got {tx,re,busy}=%b want %b", d, tr[d], exp_tr[d]); end
    tests++;
    if (fq.size() !== 1) begin fails++; $display("FAIL en_drop_fifo_left: got %0d want 1", fq.size()); end
    fq.delete();
    fifo_empty = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    int d;
    clear();
    en = 1'b1;
    load(8'hFF);
    repeat (2 + CPB + 4 * CPB + CPB / 2) tick();
    rst_ = 1'b0;
    #1;
    tests++; if (tx !== 1'b1)   begin fails++; $display("FAIL rst_mid_tx: got %b want 1", tx); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    tick(); tick();
    rst_ = 1'b1;
    tick();
    load(8'h00);
    repeat (5) tick();
    rst_ = 1'b0;
    #1;
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL rst_start_tx: got %b want 1", tx); end
    tick(); tick();
    rst_ = 1'b1;
    clear();
    repeat (100) tick();
    build_exp(100);
    d = first_diff();
    tests++;
    if (d != -1) begin fails++; $display("FAIL rst_after_idle: cycle %0d got {tx,re,busy}=%b want %b", d, tr[d], exp_tr[d]); end
  endtask

  task automatic test_random();
    int d;
    int n;
    clear();
    n = $urandom_range(3, 5);
    for (int i = 0; i < n; i++) load(8'($urandom));
    repeat (n * SLOT + 20) tick();
    build_exp(n * SLOT + 20);
    d = first_diff();
    tests++;
    if (d != -1) begin fails++; $display("FAIL random_trace: cycle %0d got {tx,re,busy}=%b want %b", d, tr[d], exp_tr[d]); end
    decode();
    tests++;
    if (rx.size() !== n) begin fails++; $display("FAIL random_count: got %0d want %0d", rx.size(), n); end
    for (int i = 0; i < n && i < rx.size(); i++) begin
      tests++;
      if (rx[i] !== sent[i]) begin fails++; $display("FAIL random_byte%0d: got %h want %h", i, rx[i], sent[i]); end
    end
    tests++;
    if (underflows !== 0) begin fails++; $display("FAIL underflow: got %0d reads of empty FIFO want 0", underflows); end
  endtask

`ifdef UART_FIFO_TX_PARITY_EN
  task automatic test_parity();
    int nb;
    int p0;
    int p1;
    clear();
    load(8'h07);
    load(8'h03);
    repeat (2 * 112 + 20) tick();
    p0 = 2 + 9 * CPB + CPB / 2;
    p1 = 112 + p0;
    tests++;
    if (tr[p0][2] !== 1'b1) begin fails++; $display("FAIL parity_07: got %b want 1", tr[p0][2]); end
    tests++;
    if (tr[p1][2] !== 1'b0) begin fails++; $display("FAIL parity_03: got %b want 0", tr[p1][2]); end
    nb = 0;
    foreach (tr[i]) if (tr[i][0]) nb++;
    tests++;
    if (nb !== 2 * 112) begin fails++; $display("FAIL parity_busy_len: got %0d want %0d", nb, 2 * 112); end
  endtask
`endif

  initial begin
    test_reset();
    test_empty_idle();
    test_single();
    test_back_to_back();
    test_en_drop();
    test_reset_mid_frame();
    test_random();
`ifdef UART_FIFO_TX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
